// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with clocked writes, bypassed reads,
// half-word write modes and a pending-write scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  output logic [DATA_W-1:0]      rd_data_a,
  output logic                   busy_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic [DATA_W-1:0]      rd_data_b,
  output logic                   busy_b,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [1:0]             wr_mode,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic                   iss_stall,
  output logic [(1<<ADDR_W)-1:0] pend_vec
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int H        = DATA_W / 2;
  localparam bit ZR       = (ZERO_REG != 0);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic                wr_ok;
  logic [DATA_W-1:0]   cur;
  logic [DATA_W-1:0]   merge;
  logic                hit_a;
  logic                hit_b;
  logic                hit_i;
  logic                zero_a;
  logic                zero_b;

  assign wr_ok = wr_en && (wr_mode != 2'b11)
              && !(ZR && (wr_addr == '0));

  assign cur = regs[wr_addr];

  always_comb begin
    merge = cur;
    unique case (wr_mode)
      2'b00: merge = wr_data;
      2'b01: merge = {cur[DATA_W-1:H], wr_data[H-1:0]};
      2'b10: merge = {wr_data[H-1:0], cur[H-1:0]};
      default: merge = cur;
    endcase
  end

  assign hit_a  = wr_ok && (wr_addr == rd_addr_a);
  assign hit_b  = wr_ok && (wr_addr == rd_addr_b);
  assign hit_i  = wr_ok && (wr_addr == iss_addr);
  assign zero_a = ZR && (rd_addr_a == '0);
  assign zero_b = ZR && (rd_addr_b == '0);

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (zero_a)     rd_data_a = '0;
    else if (hit_a) rd_data_a = merge;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (zero_b)     rd_data_b = '0;
    else if (hit_b) rd_data_b = merge;
  end

  assign busy_a    = pend[rd_addr_a] && !hit_a && !zero_a;
  assign busy_b    = pend[rd_addr_b] && !hit_b && !zero_b;
  assign iss_stall = iss_en && pend[iss_addr] && !hit_i;
  assign pend_vec  = pend;

  // A new reservation beats a retiring write to the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (iss_en && !iss_stall
            && (iss_addr == ADDR_W'(i))
            && !(ZR && i == 0))
          pend[i] <= 1'b1;
        else if (wr_ok && (wr_addr == ADDR_W'(i)))
          pend[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= merge;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector bench for reg_file_sb,
// covering both ZERO_REG builds.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        busy_a, busy_b;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [1:0]  wr_mode;
  logic [15:0] wr_data;
  logic        iss_en;
  logic [2:0]  iss_addr;
  logic        iss_stall;
  logic [7:0]  pend_vec;

  logic [15:0] rd_data_a_z, rd_data_b_z;
  logic        busy_a_z, busy_b_z;
  logic        iss_stall_z;
  logic [7:0]  pend_vec_z;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .busy_a(busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .busy_b(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mode(wr_mode),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_stall(iss_stall), .pend_vec(pend_vec)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_z), .busy_a(busy_a_z),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_z), .busy_b(busy_b_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mode(wr_mode),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_stall(iss_stall_z), .pend_vec(pend_vec_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        we;
    logic [2:0]  wa;
    logic [1:0]  wm;
    logic [15:0] wd;
    logic        ie;
    logic [2:0]  ia;
    logic [15:0] ea;
    logic        eba;
    logic [15:0] eb;
    logic        ebb;
    logic        es;
    logic [7:0]  ep;
  } vec_t;

  vec_t v [17];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ra, input logic [2:0] rb,
                       input logic we, input logic [2:0] wa,
                       input logic [1:0] wm, input logic [15:0] wd,
                       input logic ie, input logic [2:0] ia);
    rd_addr_a = ra; rd_addr_b = rb;
    wr_en = we; wr_addr = wa; wr_mode = wm; wr_data = wd;
    iss_en = ie; iss_addr = ia;
  endtask

  task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
    drive(ra, rb, 1'b0, 3'd0, 2'd0, 16'h0, 1'b0, 3'd0);
  endtask

  initial begin
    v[0]  = '{3,5, 1,3,0,16'h1234, 0,0, 16'h1234,0,16'h0000,0,0,8'h00};
    v[1]  = '{3,5, 0,0,0,16'h0000, 0,0, 16'h1234,0,16'h0000,0,0,8'h00};
    v[2]  = '{2,3, 1,2,0,16'hAAAA, 0,0, 16'hAAAA,0,16'h1234,0,0,8'h00};
    v[3]  = '{2,2, 1,2,1,16'h0055, 0,0, 16'hAA55,0,16'hAA55,0,0,8'h00};
    v[4]  = '{2,2, 1,2,2,16'h00C3, 0,0, 16'hC355,0,16'hC355,0,0,8'h00};
    v[5]  = '{2,3, 0,0,0,16'h0000, 0,0, 16'hC355,0,16'h1234,0,0,8'h00};
    v[6]  = '{4,3, 0,0,0,16'h0000, 1,4, 16'h0000,0,16'h1234,0,0,8'h00};
    v[7]  = '{4,3, 0,0,0,16'h0000, 1,4, 16'h0000,1,16'h1234,0,1,8'h10};
    v[8]  = '{4,3, 1,4,0,16'h0F0F, 1,4, 16'h0F0F,0,16'h1234,0,0,8'h10};
    v[9]  = '{4,3, 0,0,0,16'h0000, 0,0, 16'h0F0F,1,16'h1234,0,0,8'h10};
    v[10] = '{4,3, 1,4,0,16'h1111, 0,0, 16'h1111,0,16'h1234,0,0,8'h10};
    v[11] = '{4,3, 0,0,0,16'h0000, 0,0, 16'h1111,0,16'h1234,0,0,8'h00};
    v[12] = '{6,3, 0,0,0,16'h0000, 1,6, 16'h0000,0,16'h1234,0,0,8'h00};
    v[13] = '{6,6, 1,6,3,16'hFFFF, 0,0, 16'h0000,1,16'h0000,1,0,8'h40};
    v[14] = '{6,3, 0,0,0,16'h0000, 0,0, 16'h0000,1,16'h1234,0,0,8'h40};
    v[15] = '{6,5, 1,5,0,16'h5A5A, 0,0, 16'h0000,1,16'h5A5A,0,0,8'h40};
    v[16] = '{5,6, 0,0,0,16'h0000, 0,0, 16'h5A5A,0,16'h0000,1,0,8'h40};

    rst_n = 1'b0;
    idle(3'd3, 3'd5);
    repeat (2) @(negedge clk);
    #1;
    check("reset rd_a", {16'h0, rd_data_a}, 32'h0);
    check("reset pend", {24'h0, pend_vec}, 32'h0);
    check("reset stall", {31'h0, iss_stall}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(v[i].ra, v[i].rb, v[i].we, v[i].wa,
            v[i].wm, v[i].wd, v[i].ie, v[i].ia);
      #1;
      check($sformatf("v%0d rd_a", i), {16'h0, rd_data_a}, {16'h0, v[i].ea});
      check($sformatf("v%0d busy_a", i), {31'h0, busy_a}, {31'h0, v[i].eba});
      check($sformatf("v%0d rd_b", i), {16'h0, rd_data_b}, {16'h0, v[i].eb});
      check($sformatf("v%0d busy_b", i), {31'h0, busy_b}, {31'h0, v[i].ebb});
      check($sformatf("v%0d stall", i), {31'h0, iss_stall}, {31'h0, v[i].es});
      check($sformatf("v%0d pend", i), {24'h0, pend_vec}, {24'h0, v[i].ep});
    end

    @(negedge clk);
    drive(3'd0, 3'd0, 1'b1, 3'd0, 2'd0, 16'hBEEF, 1'b0, 3'd0);
    #1;
    check("z wr0 rd_a", {16'h0, rd_data_a_z}, 32'h0);
    check("nz wr0 bypass", {16'h0, rd_data_a}, 32'hBEEF);
    @(negedge clk);
    drive(3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b1, 3'd0);
    #1;
    check("z r0 after wr", {16'h0, rd_data_b_z}, 32'h0);
    check("nz r0 after wr", {16'h0, rd_data_b}, 32'hBEEF);
    check("z iss0 stall", {31'h0, iss_stall_z}, 32'h0);
    @(negedge clk);
    idle(3'd0, 3'd0);
    #1;
    check("z pend0", {31'h0, pend_vec_z[0]}, 32'h0);
    check("z busy0", {31'h0, busy_a_z}, 32'h0);
    check("nz pend0", {31'h0, pend_vec[0]}, 32'h1);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'd1, 3'd2, 1'b1, 3'd1, 2'd0, 16'h7777, 1'b1, 3'd2);
    @(negedge clk);
    drive(3'd1, 3'd2, 1'b0, 3'd0, 2'd0, 16'h0, 1'b1, 3'd3);
    @(negedge clk);
    idle(3'd1, 3'd2);
    #1;
    check("pre-rst pend", {24'h0, pend_vec}, 32'h0C);
    check("pre-rst R1", {16'h0, rd_data_a}, 32'h7777);
    check("pre-rst busy_b", {31'h0, busy_b}, 32'h1);
    #2;
    rst_n = 1'b0;
    iss_en = 1'b1;
    iss_addr = 3'd2;
    #1;
    check("rst pend", {24'h0, pend_vec}, 32'h0);
    check("rst R1", {16'h0, rd_data_a}, 32'h0);
    check("rst busy_b", {31'h0, busy_b}, 32'h0);
    check("rst stall", {31'h0, iss_stall}, 32'h0);
    @(negedge clk);
    drive(3'd2, 3'd2, 1'b1, 3'd1, 2'd0, 16'h9999, 1'b0, 3'd0);
    @(negedge clk);
    idle(3'd1, 3'd2);
    #1;
    check("wr under rst", {16'h0, rd_data_a}, 32'h0);
    rst_n = 1'b1;
    drive(3'd2, 3'd2, 1'b1, 3'd1, 2'd0, 16'h2222, 1'b0, 3'd0);
    @(negedge clk);
    idle(3'd1, 3'd2);
    #1;
    check("wr after rel", {16'h0, rd_data_a}, 32'h2222);
    check("pend after rel", {24'h0, pend_vec}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised general-purpose register file for the 16-bit CPU with clocked writes and two combinational read ports with write bypass. Supports the half-word write modes used by SETH/SETL and a per-register pending-write scoreboard. The control unit uses the scoreboard to detect RAW/WAW hazards on multi-cycle results. Sits between the decode/control stage, which issues reads and destination reservations, and the ALU/move result path, which writes back.

Parameters:
DATA_W, 16, register width in bits; must be even and >= 2.
ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W.
ZERO_REG, 0, if 1 then register 0 reads as zero, ignores writes and is never pending.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
rd_addr_a  in  ADDR_W  read port A address.
rd_data_a  out  DATA_W  read port A data (combinational, bypassed).
busy_a  out  1  register at rd_addr_a has an outstanding write not being satisfied this cycle.
rd_addr_b  in  ADDR_W  read port B address.
rd_data_b  out  DATA_W  read port B data (combinational, bypassed).
busy_b  out  1  as busy_a for port B.
wr_en  in  1  write-back strobe.
wr_addr  in  ADDR_W  write-back destination.
wr_mode  in  2  00 full word, 01 low half (SETL), 10 high half (SETH), 11 reserved.
wr_data  in  DATA_W  write-back data.
iss_en  in  1  reserve iss_addr as pending destination.
iss_addr  in  ADDR_W  destination being reserved.
iss_stall  out  1  reservation refused (WAW hazard); control must hold the instruction.
pend_vec  out  NUM_REGS  current pending bits, bit i = register i.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, pend_vec = 0. Combinational outputs follow: rd_data = 0 unless bypassed, busy_a/busy_b = 0, iss_stall = 0. Reset asserted mid-write discards that write.
- Valid write: wr_en=1, wr_mode!=11, and not (ZERO_REG=1 and wr_addr=0).
- Write merge value M for the addressed register R:
  - mode 00: M = wr_data.
  - mode 01: M = {R[DATA_W-1:DATA_W/2], wr_data[DATA_W/2-1:0]}.
  - mode 10: M = {wr_data[DATA_W/2-1:0], R[DATA_W/2-1:0]}.
  - On the rising edge R <= M. Mode 11 writes nothing and clears nothing.
- Reads are combinational, zero latency:
  - If a valid write targets the read address, rd_data = M (bypass).
  - Otherwise rd_data = stored value.
  - ZERO_REG=1 and address 0: rd_data = 0 always.
  - Both ports may read the same register.
- Scoreboard, per register i, at the rising edge:
  - Set when iss_en=1, iss_addr=i and iss_stall=0.
  - Else cleared when a valid write targets i (any mode 00/01/10).
  - Else held.
  - Set and clear on the same register in the same cycle: set wins, pend=1 (new producer).
- busy_x = pend[rd_addr_x] and not (valid write to rd_addr_x this cycle). Bypass satisfies the hazard. Always 0 for register 0 when ZERO_REG=1.
- iss_stall = iss_en and pend[iss_addr] and not (valid write to iss_addr this cycle). On a stall, pend is unchanged by the issue.
- iss_en with ZERO_REG=1 and iss_addr=0: accepted, no pend bit set, iss_stall=0.
- A write to a non-pending register is legal: data updates, pend stays 0.
- No other internal state. The block never generates X from defined inputs.

Test Plan:
1. Reset then full writes: write 0x1234 to R3 mode 00, next cycle read A=R3 -> 0x1234. Read B=R5 -> 0x0000.
2. Half writes: R2=0xAAAA; SETL wr_data=0x0055 -> R2=0xAA55; then SETH wr_data=0x00C3 -> R2=0xC355.
   - During the SETH cycle, rd_addr_a=2 shows 0xC355 (bypass).
3. Scoreboard:
   - iss R4 -> pend_vec=0x10, busy_a=1 for rd_addr_a=4.
   - Second iss R4 -> iss_stall=1, pend unchanged.
   - Write R4=0x0F0F in the same cycle as a re-issue of R4 -> iss_stall=0, busy_a=0, rd_data_a=0x0F0F, pend_vec stays 0x10.
4. Reserved mode: wr_mode=11 to pending R6 with 0xFFFF -> R6 unchanged, pend[6] stays 1, busy=1.
5. ZERO_REG=1 build:
   - Write 0xBEEF to R0 -> reads 0.
   - iss R0 -> pend_vec bit 0 stays 0, no stall.
6. Async reset mid-operation: pend_vec=0x0C, R1=0x7777; drop rst_n between edges -> all outputs 0 immediately. A write presented on the reset-release edge cycle is ignored until rst_n is high at an edge.
